// File: rtl/accumulator_sequencer.sv
// Controller that runs one external accumulator through a weighted-sum pass:
// load a bias, add num_terms streamed samples, then publish sum, sign and overflow.
module accumulator_sequencer #(
    parameter int IN_WIDTH  = 14,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic signed [IN_WIDTH:0]   init_in,
    input  logic [CNT_WIDTH-1:0]       num_terms,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [IN_WIDTH-1:0] s_data,
    output logic                       acc_load,
    output logic                       acc_add,
    output logic signed [IN_WIDTH:0]   acc_init,
    output logic signed [IN_WIDTH-1:0] acc_a,
    input  logic signed [IN_WIDTH:0]   acc_y,
    input  logic                       acc_ovf,
    output logic                       busy,
    output logic                       done,
    output logic signed [IN_WIDTH:0]   result,
    output logic                       sign,
    output logic                       ovf_flag
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        WAIT,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_next;
    logic [CNT_WIDTH-1:0] terms;
    logic                 beat;

    // s_ready is registered and only high in ACCUM, so a handshake implies ACCUM.
    assign beat       = s_ready && s_valid;
    assign acc_add    = beat;
    assign acc_a      = beat ? s_data : '0;
    assign count_next = count + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            terms    <= '0;
            s_ready  <= 1'b0;
            acc_load <= 1'b0;
            acc_init <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            sign     <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            done     <= 1'b0;
            acc_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_init <= init_in;
                        terms    <= num_terms;
                        count    <= '0;
                        ovf_flag <= 1'b0;
                        acc_load <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (terms == '0) begin
                        state <= WAIT;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (beat) begin
                        count <= count_next;
                        if (acc_ovf) begin
                            ovf_flag <= 1'b1;
                        end
                        if (count_next == terms) begin
                            s_ready <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // The last add registered on the previous edge, so acc_y is final here.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        result <= acc_y;
                        sign   <= acc_y[IN_WIDTH];
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Scoreboard bench for accumulator_sequencer with a behavioural accumulator attached.
module tb_accumulator_sequencer;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic signed [14:0] init_in = '0;
    logic [7:0]         num_terms = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [13:0] s_data = '0;
    logic               acc_load;
    logic               acc_add;
    logic signed [14:0] acc_init;
    logic signed [13:0] acc_a;
    logic signed [14:0] acc_y;
    logic               acc_ovf;
    logic               busy;
    logic               done;
    logic signed [14:0] result;
    logic               sign;
    logic               ovf_flag;

    int checks = 0;
    int errors = 0;
    int smp[8];

    typedef struct packed {
        logic [14:0] r;
        logic        s;
        logic        o;
    } exp_t;
    exp_t exp_q[$];

    accumulator_sequencer #(.IN_WIDTH(14), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .init_in(init_in), .num_terms(num_terms),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .acc_load(acc_load), .acc_add(acc_add), .acc_init(acc_init), .acc_a(acc_a),
        .acc_y(acc_y), .acc_ovf(acc_ovf),
        .busy(busy), .done(done), .result(result), .sign(sign), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    // External accumulator: wrapping 15-bit register with signed-overflow detect.
    logic signed [14:0] a_ext;
    logic signed [14:0] acc_sum;
    assign a_ext   = {acc_a[13], acc_a};
    assign acc_sum = acc_y + a_ext;
    assign acc_ovf = acc_add && (acc_y[14] == a_ext[14]) && (acc_sum[14] != acc_y[14]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        acc_y <= '0;
        else if (acc_load) acc_y <= acc_init;
        else if (acc_add)  acc_y <= acc_sum;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (acc_load) check("load_add_exclusive", {31'd0, acc_add}, 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", {{17{result[14]}}, result}, {{17{e.r[14]}}, e.r});
                check("sign", {31'd0, sign}, {31'd0, e.s});
                check("ovf_flag", {31'd0, ovf_flag}, {31'd0, e.o});
            end
        end
    end

    task automatic send_beat(input int val);
        int t;
        s_valid = 1'b1;
        s_data  = val[13:0];
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("beat_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic issue_start(input int init, input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        init_in   = init[14:0];
        num_terms = n[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_pass(input int init, input int n, input int gap,
                            input int exp_res, input int exp_sign, input int exp_ovf, input int exp_lat);
        int k;
        exp_t e;
        e.r = exp_res[14:0];
        e.s = exp_sign[0];
        e.o = exp_ovf[0];
        exp_q.push_back(e);
        issue_start(init, n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    check("add_low_in_gap", {31'd0, acc_add}, 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(smp[i]);
        end
        k = 1;
        @(negedge clk);
        if (n == 0) check("no_ready_n0", {31'd0, s_ready}, 32'd0);
        while (!done && k < 10) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) check("no_ready_n0", {31'd0, s_ready}, 32'd0);
            k++;
        end
        check("latency", k, exp_lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, s_ready}, 32'd0);
        check("rst_result", {17'd0, result}, 32'd0);
        check("rst_load", {31'd0, acc_load}, 32'd0);
        reset = 1'b1;

        // 1: back-to-back beats
        smp[0] = 5; smp[1] = -7; smp[2] = 20;
        run_pass(100, 3, 0, 118, 0, 0, 2);
        // 2: gaps between beats, negative result
        smp[0] = 10; smp[1] = -3;
        run_pass(-50, 2, 2, -43, 1, 0, 2);
        // 3: zero terms
        run_pass(-1, 0, 0, -1, 1, 0, 3);
        // 4: wrap through overflow and back
        smp[0] = 1; smp[1] = -1;
        run_pass(16383, 2, 0, 16383, 0, 1, 2);

        // 5: abort after one of four beats
        issue_start(7, 4);
        send_beat(9);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, s_ready}, 32'd0);
        check("abort_result_kept", {{17{result[14]}}, result}, 32'd16383);
        check("abort_sign_kept", {31'd0, sign}, 32'd0);
        repeat (4) @(posedge clk);
        smp[0] = 1; smp[1] = 2; smp[2] = 3; smp[3] = 4;
        run_pass(7, 4, 0, 17, 0, 0, 2);

        // 6: reset in the middle of ACCUM
        issue_start(50, 3);
        send_beat(1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, s_ready}, 32'd0);
        check("mid_rst_result", {17'd0, result}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf_flag}, 32'd0);
        check("mid_rst_init", {17'd0, acc_init}, 32'd0);
        check("mid_rst_load", {31'd0, acc_load}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        smp[0] = 4;
        run_pass(3, 1, 0, 7, 0, 0, 2);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
